xadc_drp_responder: RTL and testbench

Synthesizable DRP responder that emulates the XADC dynamic reconfiguration port and channel sequencer, so the bridge's DRP-initiating logic can be exercised in simulation and on boards without the hard XADC. It accepts DRP reads and writes, returns data with a fixed latency, and runs a four-channel auxiliary sequence (VAUX0–VAUX3) that converts sample inputs into status registers 0x10–0x13 and signals EOC and EOS.

---
 rtl/xadc_drp_responder.sv | 200 ++++++++++++++++++++
 tb/tb_xadc_drp_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_responder.sv
// Behavioural stand-in for the XADC DRP port and auxiliary channel sequencer (VAUX0-VAUX3).
// DRP reads return data a fixed RD_LATENCY cycles after DEN; status regs 0x10-0x13 track samples.
module xadc_drp_responder #(
  parameter int unsigned RD_LATENCY  = 4,
  parameter int unsigned CONV_CYCLES = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic        BUSY,
  output logic        EOC,
  output logic        EOS,
  output logic [4:0]  CHANNEL,
  input  logic        seq_enable,
  input  logic [11:0] aux_sample0,
  input  logic [11:0] aux_sample1,
  input  logic [11:0] aux_sample2,
  input  logic [11:0] aux_sample3,
  output logic        drp_err
);

  typedef enum logic [1:0] {DIdle, DWait, DResp} drp_state_e;
  typedef enum logic [0:0] {SIdle, SConv} seq_state_e;

  localparam logic [3:0] LatLoad  = 4'(RD_LATENCY - 1);
  localparam logic [7:0] ConvLast = 8'(CONV_CYCLES - 1);

  drp_state_e  drp_state_q, drp_state_d;
  seq_state_e  seq_state_q, seq_state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [6:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] di_q, di_d;
  logic [15:0] cap_q, cap_d;
  logic        err_q, err_d;
  logic        drdy_q, drdy_d;
  logic [15:0] do_q, do_d;
  logic [15:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic [15:0] stat_q [4];
  logic [15:0] stat_d [4];
  logic [1:0]  k_q, k_d;
  logic [7:0]  cyc_q, cyc_d;
  logic        busy_q, busy_d, eoc_q, eoc_d, eos_q, eos_d;
  logic [4:0]  channel_q, channel_d;
  logic [15:0] rdata;
  logic [11:0] aux [4];

  assign aux[0] = aux_sample0;
  assign aux[1] = aux_sample1;
  assign aux[2] = aux_sample2;
  assign aux[3] = aux_sample3;

  // Read data is taken from current register contents, so a same-cycle status update is not seen.
  always_comb begin
    rdata = 16'h0000;
    case (DADDR)
      7'h10, 7'h11, 7'h12, 7'h13: rdata = stat_q[DADDR[1:0]];
      7'h40:                      rdata = cfg0_q;
      7'h41:                      rdata = cfg1_q;
      7'h42:                      rdata = cfg2_q;
      default:                    rdata = 16'h0000;
    endcase
  end

  always_comb begin
    drp_state_d = drp_state_q;
    lat_cnt_d   = lat_cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    di_d        = di_q;
    cap_d       = cap_q;
    err_d       = err_q;
    cfg0_d      = cfg0_q;
    cfg1_d      = cfg1_q;
    cfg2_d      = cfg2_q;
    case (drp_state_q)
      DIdle: begin
        if (DEN) begin
          addr_d      = DADDR;
          we_d        = DWE;
          di_d        = DI;
          cap_d       = rdata;
          lat_cnt_d   = LatLoad;
          drp_state_d = (RD_LATENCY == 1) ? DResp : DWait;
        end
      end
      DWait: begin
        if (lat_cnt_q == 4'd1) drp_state_d = DResp;
        else                   lat_cnt_d   = lat_cnt_q - 4'd1;
      end
      DResp: begin
        drp_state_d = DIdle;
        if (we_q) begin
          case (addr_q)
            7'h40:   cfg0_d = di_q;
            7'h41:   cfg1_d = di_q;
            7'h42:   cfg2_d = di_q;
            default: ;
          endcase
        end
      end
      default: drp_state_d = DIdle;
    endcase
    if (DEN && (drp_state_q != DIdle)) err_d = 1'b1;
    drdy_d = (drp_state_d == DResp);
    do_d   = (drdy_d && !we_d) ? cap_d : 16'h0000;
  end

  always_comb begin
    seq_state_d = seq_state_q;
    k_d         = k_q;
    cyc_d       = cyc_q;
    stat_d      = stat_q;
    case (seq_state_q)
      SIdle: begin
        if (seq_enable) begin
          seq_state_d = SConv;
          k_d         = 2'd0;
          cyc_d       = 8'd0;
        end
      end
      SConv: begin
        if (cyc_q == ConvLast) begin
          stat_d[k_q] = {aux[k_q], 4'h0};
          cyc_d       = 8'd0;
          k_d         = k_q + 2'd1;
          // A dropped seq_enable only takes effect at the end of a full sequence.
          if (k_q == 2'd3 && !seq_enable) seq_state_d = SIdle;
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      default: seq_state_d = SIdle;
    endcase
    busy_d    = (seq_state_d == SConv);
    eoc_d     = busy_d && (cyc_d == ConvLast);
    eos_d     = eoc_d && (k_d == 2'd3);
    channel_d = busy_d ? {3'b100, k_d} : channel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drp_state_q <= DIdle;
      seq_state_q <= SIdle;
      lat_cnt_q   <= 4'd0;
      addr_q      <= 7'd0;
      we_q        <= 1'b0;
      di_q        <= 16'h0000;
      cap_q       <= 16'h0000;
      err_q       <= 1'b0;
      drdy_q      <= 1'b0;
      do_q        <= 16'h0000;
      cfg0_q      <= 16'h0000;
      cfg1_q      <= 16'h0000;
      cfg2_q      <= 16'h0000;
      stat_q      <= '{default: 16'h0000};
      k_q         <= 2'd0;
      cyc_q       <= 8'd0;
      busy_q      <= 1'b0;
      eoc_q       <= 1'b0;
      eos_q       <= 1'b0;
      channel_q   <= 5'h10;
    end else begin
      drp_state_q <= drp_state_d;
      seq_state_q <= seq_state_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      di_q        <= di_d;
      cap_q       <= cap_d;
      err_q       <= err_d;
      drdy_q      <= drdy_d;
      do_q        <= do_d;
      cfg0_q      <= cfg0_d;
      cfg1_q      <= cfg1_d;
      cfg2_q      <= cfg2_d;
      stat_q      <= stat_d;
      k_q         <= k_d;
      cyc_q       <= cyc_d;
      busy_q      <= busy_d;
      eoc_q       <= eoc_d;
      eos_q       <= eos_d;
      channel_q   <= channel_d;
    end
  end

  assign DO      = do_q;
  assign DRDY    = drdy_q;
  assign BUSY    = busy_q;
  assign EOC     = eoc_q;
  assign EOS     = eos_q;
  assign CHANNEL = channel_q;
  assign drp_err = err_q;

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Self-checking bench for xadc_drp_responder: random DRP traffic against a register-map model,
// sequencer timing derived from cycle arithmetic, collision and mid-operation reset scenarios.
module tb_xadc_drp_responder;

  localparam int RdLat = 4;
  localparam int Conv  = 26;

  logic        clk;
  logic        rst;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;
  logic        BUSY;
  logic        EOC;
  logic        EOS;
  logic [4:0]  CHANNEL;
  logic        seq_enable;
  logic [11:0] aux_sample0, aux_sample1, aux_sample2, aux_sample3;
  logic        drp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] model_cfg  [3];
  logic [15:0] model_stat [4];

  xadc_drp_responder #(
    .RD_LATENCY (RdLat),
    .CONV_CYCLES(Conv)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .DADDR      (DADDR),
    .DEN        (DEN),
    .DWE        (DWE),
    .DI         (DI),
    .DO         (DO),
    .DRDY       (DRDY),
    .BUSY       (BUSY),
    .EOC        (EOC),
    .EOS        (EOS),
    .CHANNEL    (CHANNEL),
    .seq_enable (seq_enable),
    .aux_sample0(aux_sample0),
    .aux_sample1(aux_sample1),
    .aux_sample2(aux_sample2),
    .aux_sample3(aux_sample3),
    .drp_err    (drp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_read(input logic [6:0] a);
    int idx = int'(a);
    if (idx >= 16 && idx <= 19) return model_stat[idx - 16];
    if (idx >= 64 && idx <= 66) return model_cfg[idx - 64];
    return 16'h0000;
  endfunction

  function automatic void model_write(input logic [6:0] a, input logic [15:0] d);
    int idx = int'(a);
    if (idx >= 64 && idx <= 66) model_cfg[idx - 64] = d;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) model_cfg[i] = 16'h0000;
    for (int i = 0; i < 4; i++) model_stat[i] = 16'h0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One DRP transaction; lat is -1 if no DRDY arrives within the budget.
  task automatic drp_xfer(input logic [6:0] a, input logic we, input logic [15:0] d,
                          output logic [15:0] dout, output int lat, output logic drdy_next);
    DADDR = a; DWE = we; DI = d; DEN = 1'b1;
    lat = 0;
    do begin
      tick();
      DEN = 1'b0;
      lat++;
    end while (DRDY !== 1'b1 && lat < 40);
    dout = DO;
    if (DRDY !== 1'b1) lat = -1;
    tick();
    drdy_next = DRDY;
  endtask

  task automatic test_reset();
    tests_run++;
    if (DO !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_do: got %h expected 0000", DO);
    end
    tests_run++;
    if ({DRDY, BUSY, EOC, EOS} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_strobes: got %b expected 0000", {DRDY, BUSY, EOC, EOS});
    end
    tests_run++;
    if (CHANNEL !== 5'h10) begin
      tests_failed++; $display("FAIL reset_channel: got %h expected 10", CHANNEL);
    end
    tests_run++;
    if (drp_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_drp_err: got %b expected 0", drp_err);
    end
  endtask

  task automatic test_read_after_reset();
    logic [15:0] dout; int lat; logic nxt;
    drp_xfer(7'h10, 1'b0, 16'h0, dout, lat, nxt);
    tests_run++;
    if (lat != RdLat || dout !== 16'h0000) begin
      tests_failed++;
      $display("FAIL read_after_reset: got lat=%0d do=%h expected lat=%0d do=0000", lat, dout, RdLat);
    end
    tests_run++;
    if (nxt !== 1'b0) begin
      tests_failed++; $display("FAIL drdy_one_cycle: got drdy=%b next cycle expected 0", nxt);
    end
  endtask

  task automatic test_write_readback();
    logic [15:0] dout, d, exp; int lat; logic nxt; logic [6:0] a; logic we;
    int bad;
    drp_xfer(7'h40, 1'b1, 16'hA5C3, dout, lat, nxt);
    model_write(7'h40, 16'hA5C3);
    tests_run++;
    if (lat != RdLat || dout !== 16'h0000) begin
      tests_failed++; $display("FAIL write_resp: got lat=%0d do=%h expected lat=%0d do=0000", lat, dout, RdLat);
    end
    drp_xfer(7'h40, 1'b0, 16'h0, dout, lat, nxt);
    tests_run++;
    if (dout !== 16'hA5C3) begin
      tests_failed++; $display("FAIL readback_40: got %h expected a5c3", dout);
    end
    drp_xfer(7'h7F, 1'b0, 16'h0, dout, lat, nxt);
    tests_run++;
    if (dout !== 16'h0000) begin
      tests_failed++; $display("FAIL read_7f: got %h expected 0000", dout);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 7'(16 + $urandom_range(0, 3));
        1:       a = 7'(64 + $urandom_range(0, 2));
        2:       a = 7'(67 + $urandom_range(0, 4));
        default: a = 7'($urandom_range(0, 127));
      endcase
      we  = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      exp = we ? 16'h0000 : model_read(a);
      drp_xfer(a, we, d, dout, lat, nxt);
      if (we) model_write(a, d);
      tests_run++;
      if (dout !== exp || lat != RdLat || nxt !== 1'b0) begin
        tests_failed++; bad++;
        $display("FAIL random_xfer[%0d] addr=%h we=%b: got do=%h lat=%0d expected do=%h lat=%0d",
                 i, a, we, dout, lat, exp, RdLat);
      end
    end
  endtask

  // Start the sequencer at cycle 0; drop seq_enable at cycle drop_at; expect n_seq full sequences.
  task automatic test_sequence(input logic [11:0] s0, input logic [11:0] s1,
                               input logic [11:0] s2, input logic [11:0] s3,
                               input int drop_at, input int n_seq);
    logic [11:0] samp [4];
    int total, k, e_busy, e_eoc, e_eos, e_ch;
    logic exp_busy, exp_eoc, exp_eos;
    logic [4:0] exp_ch;
    logic [15:0] dout; int lat; logic nxt;
    samp[0] = s0; samp[1] = s1; samp[2] = s2; samp[3] = s3;
    aux_sample0 = s0; aux_sample1 = s1; aux_sample2 = s2; aux_sample3 = s3;
    total = n_seq * 4 * Conv;
    e_busy = 0; e_eoc = 0; e_eos = 0; e_ch = 0;
    seq_enable = 1'b1;
    for (int n = 1; n <= total + 2; n++) begin
      tick();
      if (n == drop_at) seq_enable = 1'b0;
      k        = ((n - 1) / Conv) % 4;
      exp_busy = (n <= total);
      exp_eoc  = exp_busy && (n % Conv == 0);
      exp_eos  = exp_busy && (n % (4 * Conv) == 0);
      exp_ch   = exp_busy ? 5'(16 + k) : 5'h13;
      if (BUSY !== exp_busy) e_busy++;
      if (EOC !== exp_eoc) e_eoc++;
      if (EOS !== exp_eos) e_eos++;
      if (CHANNEL !== exp_ch) e_ch++;
      if (exp_eoc) model_stat[k] = {samp[k], 4'h0};
    end
    tests_run++;
    if (e_busy != 0) begin
      tests_failed++; $display("FAIL seq_busy: got %0d bad cycles expected 0", e_busy);
    end
    tests_run++;
    if (e_eoc != 0) begin
      tests_failed++; $display("FAIL seq_eoc: got %0d bad cycles expected 0", e_eoc);
    end
    tests_run++;
    if (e_eos != 0) begin
      tests_failed++; $display("FAIL seq_eos: got %0d bad cycles expected 0", e_eos);
    end
    tests_run++;
    if (e_ch != 0) begin
      tests_failed++; $display("FAIL seq_channel: got %0d bad cycles expected 0", e_ch);
    end
    for (int i = 0; i < 4; i++) begin
      drp_xfer(7'(16 + i), 1'b0, 16'h0, dout, lat, nxt);
      tests_run++;
      if (dout !== model_stat[i]) begin
        tests_failed++; $display("FAIL seq_status[%0d]: got %h expected %h", i, dout, model_stat[i]);
      end
    end
  endtask

  task automatic test_collision();
    int n_drdy, first_at;
    logic [15:0] got, dout; int lat; logic nxt;
    n_drdy = 0; first_at = -1; got = '0;
    DADDR = 7'h40; DWE = 1'b0; DI = 16'h0; DEN = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      DEN = (n == 2);
      if (n == 2) begin
        DADDR = 7'h41; DWE = 1'b1; DI = ~model_cfg[1];
      end
      if (DRDY === 1'b1) begin
        n_drdy++;
        if (first_at < 0) begin first_at = n; got = DO; end
      end
    end
    tests_run++;
    if (n_drdy != 1 || first_at != RdLat) begin
      tests_failed++;
      $display("FAIL collision_drdy: got count=%0d at=%0d expected count=1 at=%0d", n_drdy, first_at, RdLat);
    end
    tests_run++;
    if (got !== model_cfg[0]) begin
      tests_failed++; $display("FAIL collision_data: got %h expected %h", got, model_cfg[0]);
    end
    tests_run++;
    if (drp_err !== 1'b1) begin
      tests_failed++; $display("FAIL collision_err: got %b expected 1", drp_err);
    end
    drp_xfer(7'h41, 1'b0, 16'h0, dout, lat, nxt);
    tests_run++;
    if (dout !== model_cfg[1]) begin
      tests_failed++; $display("FAIL collision_ignored_write: got %h expected %h", dout, model_cfg[1]);
    end
    tests_run++;
    if (drp_err !== 1'b1) begin
      tests_failed++; $display("FAIL err_sticky: got %b expected 1", drp_err);
    end
  endtask

  task automatic test_reset_mid_op();
    int n_drdy, n_eoc, n_busy;
    logic [15:0] dout; int lat; logic nxt;
    seq_enable = 1'b1;
    tick();
    seq_enable = 1'b0;
    repeat (3) tick();
    DADDR = 7'h40; DWE = 1'b0; DEN = 1'b1;
    tick();
    DEN = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    tests_run++;
    if ({DRDY, BUSY, EOC, EOS, drp_err} !== 5'b00000 || DO !== 16'h0000 || CHANNEL !== 5'h10) begin
      tests_failed++;
      $display("FAIL rst_mid_op: got drdy=%b busy=%b eoc=%b eos=%b err=%b do=%h ch=%h expected all reset values",
               DRDY, BUSY, EOC, EOS, drp_err, DO, CHANNEL);
    end
    n_drdy = 0; n_eoc = 0; n_busy = 0;
    for (int n = 0; n < 2 * Conv; n++) begin
      tick();
      if (DRDY === 1'b1) n_drdy++;
      if (EOC === 1'b1 || EOS === 1'b1) n_eoc++;
      if (BUSY === 1'b1) n_busy++;
    end
    tests_run++;
    if (n_drdy != 0 || n_eoc != 0 || n_busy != 0) begin
      tests_failed++;
      $display("FAIL rst_cancel: got drdy=%0d eoc/eos=%0d busy=%0d expected 0 0 0", n_drdy, n_eoc, n_busy);
    end
    drp_xfer(7'h40, 1'b0, 16'h0, dout, lat, nxt);
    tests_run++;
    if (dout !== model_read(7'h40)) begin
      tests_failed++; $display("FAIL rst_cfg_cleared: got %h expected %h", dout, model_read(7'h40));
    end
    drp_xfer(7'h11, 1'b0, 16'h0, dout, lat, nxt);
    tests_run++;
    if (dout !== model_read(7'h11)) begin
      tests_failed++; $display("FAIL rst_status_cleared: got %h expected %h", dout, model_read(7'h11));
    end
  endtask

  initial begin
    rst = 1'b1; DADDR = '0; DEN = 1'b0; DWE = 1'b0; DI = '0; seq_enable = 1'b0;
    aux_sample0 = '0; aux_sample1 = '0; aux_sample2 = '0; aux_sample3 = '0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_read_after_reset();
    test_write_readback();
    test_sequence(12'h123, 12'hFFF, 12'h000, 12'h800, Conv + 5, 1);
    test_sequence(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 6 * Conv + 3, 2);
    test_collision();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
